// File: rtl/mul4_eval_pkg.sv
// mul4_eval_pkg: shared FSM states, lane stimulus and golden product words for mul4 evaluation
// Bit-sliced lane i drives a1=i[3], a0=i[2], b1=i[1], b0=i[0]; golden words hold {a1,a0}*{b1,b0} per lane.
package mul4_eval_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, SCORE, REPORT, DONE} state_t;
    localparam int SCORE_W = 7;
    localparam logic [15:0] LANE_A1 = 16'hFF00;
    localparam logic [15:0] LANE_A0 = 16'hF0F0;
    localparam logic [15:0] LANE_B1 = 16'hCCCC;
    localparam logic [15:0] LANE_B0 = 16'hAAAA;
    localparam logic [15:0] GOLD_Y3 = 16'h8000;
    localparam logic [15:0] GOLD_Y2 = 16'h4C00;
    localparam logic [15:0] GOLD_Y1 = 16'h6AC0;
    localparam logic [15:0] GOLD_Y0 = 16'hA0A0;
    localparam logic [63:0] GOLD = {GOLD_Y3, GOLD_Y2, GOLD_Y1, GOLD_Y0};
endpackage

// File: rtl/mul4_fitness_sequencer_if.sv
// mul4_fitness_sequencer_if: candidate datapath and result stream between sequencer and candidate mux/consumer
// Datapath: cand_sel, dp_a1/a0/b1/b0 (stimulus out), dp_y3..y0 (candidate outputs back).
// Result stream: res_valid/res_ready handshake carrying res_cand and res_score.
interface mul4_fitness_sequencer_if
    import mul4_eval_pkg::*;
#(
    parameter int CAND_W = 4
);
    logic [CAND_W-1:0] cand_sel;
    logic [15:0] dp_a1, dp_a0, dp_b1, dp_b0;
    logic [15:0] dp_y3, dp_y2, dp_y1, dp_y0;
    logic res_valid, res_ready;
    logic [CAND_W-1:0] res_cand;
    logic [SCORE_W-1:0] res_score;
    modport master (
        output cand_sel, dp_a1, dp_a0, dp_b1, dp_b0, res_valid, res_cand, res_score,
        input dp_y3, dp_y2, dp_y1, dp_y0, res_ready
    );
    modport slave (
        input cand_sel, dp_a1, dp_a0, dp_b1, dp_b0, res_valid, res_cand, res_score,
        output dp_y3, dp_y2, dp_y1, dp_y0, res_ready
    );
endinterface

// File: rtl/mul4_score.sv
// mul4_score: number of output bits (0..64) matching the golden 2x2 product truth table
// y: {y3,y2,y1,y0} captured candidate outputs; score: 64 - popcount(y ^ golden).
module mul4_score
    import mul4_eval_pkg::*;
(
    input  logic [63:0]        y,
    output logic [SCORE_W-1:0] score
);
    logic [63:0] d;
    logic [SCORE_W-1:0] err;
    assign d = y ^ GOLD;
    always_comb begin
        err = '0;
        for (int i = 0; i < 64; i++) err = err + SCORE_W'(d[i]);
        score = SCORE_W'(64) - err;
    end
endmodule

// File: rtl/mul4_fitness_sequencer.sv
// mul4_fitness_sequencer: scores candidate 2x2 multipliers one at a time and tracks the best
// clk, rst_n (async active-low); start/abort pulses; num_cand candidates per run (clamped to MAX_CAND);
// bus: cand_sel + bit-sliced stimulus out, candidate outputs in, res_* valid/ready result stream;
// best_cand/best_score: lowest index with max score this run; busy while evaluating; done 1-cycle pulse at run end.
module mul4_fitness_sequencer
    import mul4_eval_pkg::*;
#(
    parameter int MAX_CAND = 16,
    parameter int SETTLE = 2,
    localparam int CAND_W = $clog2(MAX_CAND)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CAND_W:0]         num_cand,
    output logic [CAND_W-1:0]       best_cand,
    output logic [SCORE_W-1:0]      best_score,
    output logic                    busy,
    output logic                    done,
    mul4_fitness_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CAND_W:0] MAXN = (CAND_W + 1)'(MAX_CAND);
    state_t state, nxt, launch;
    logic [CAND_W-1:0] sel, rcand, bcand;
    logic [CAND_W:0] n;
    logic [CNT_W-1:0] cnt;
    logic [63:0] cap;
    logic [SCORE_W-1:0] score, rscore, bscore;
    logic go, drv, last, acc;
    mul4_score u_score (.y(cap), .score(score));
    assign go = (state == IDLE || state == DONE) && start && !abort;
    assign launch = num_cand == '0 ? DONE : DRIVE;
    assign last = {1'b0, sel} == n - 1'b1;
    assign acc = state == REPORT && bus.res_ready;
    assign drv = state == DRIVE || state == CAPTURE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? launch : IDLE;
            DRIVE:   nxt = cnt == CNT_W'(SETTLE - 1) ? CAPTURE : DRIVE;
            CAPTURE: nxt = SCORE;
            SCORE:   nxt = REPORT;
            REPORT:  nxt = acc ? (last ? DONE : DRIVE) : REPORT;
            DONE:    nxt = go ? launch : IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            n      <= '0;
            cap    <= '0;
            rscore <= '0;
            rcand  <= '0;
            bscore <= '0;
            bcand  <= '0;
        end else begin
            state <= nxt;
            cnt   <= state == DRIVE ? cnt + 1'b1 : '0;
            if (go) begin
                sel    <= '0;
                n      <= num_cand > MAXN ? MAXN : num_cand;
                bscore <= '0;
                bcand  <= '0;
            end
            if (acc && !last && !abort) sel <= sel + 1'b1;
            if (state == CAPTURE) cap <= {bus.dp_y3, bus.dp_y2, bus.dp_y1, bus.dp_y0};
            if (state == SCORE) begin
                rscore <= score;
                rcand  <= sel;
                // candidate 0 always seeds the best; later ones need a strictly higher score
                if (sel == '0 || score > bscore) begin
                    bscore <= score;
                    bcand  <= sel;
                end
            end
        end
    end
    assign bus.cand_sel  = sel;
    assign bus.dp_a1     = drv ? LANE_A1 : '0;
    assign bus.dp_a0     = drv ? LANE_A0 : '0;
    assign bus.dp_b1     = drv ? LANE_B1 : '0;
    assign bus.dp_b0     = drv ? LANE_B0 : '0;
    assign bus.res_valid = state == REPORT;
    assign bus.res_cand  = rcand;
    assign bus.res_score = rscore;
    assign best_cand     = bcand;
    assign best_score    = bscore;
    assign busy          = drv || state == SCORE || state == REPORT;
    assign done          = state == DONE;
endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// tb_mul4_fitness_sequencer: directed vector table plus multi-cycle sequences for the fitness sequencer
module tb_mul4_fitness_sequencer;
    localparam logic [63:0] G = 64'h8000_4C00_6AC0_A0A0;
    typedef struct {
        logic [63:0] y;
        logic [6:0]  score;
    } vec_t;
    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [4:0] num_cand = 0;
    logic [3:0] best_cand;
    logic [6:0] best_score;
    logic busy, done;
    logic [63:0] tab [16];
    vec_t vecs [6];
    int pass = 0, total = 0;
    mul4_fitness_sequencer_if #(.CAND_W(4)) bus();
    mul4_fitness_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_cand(num_cand),
        .best_cand(best_cand), .best_score(best_score), .busy(busy), .done(done), .bus(bus)
    );
    always #5 clk = ~clk;
    assign {bus.dp_y3, bus.dp_y2, bus.dp_y1, bus.dp_y0} = tab[bus.cand_sel];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic kick(input logic [4:0] n);
        num_cand = n;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("valid_seen", bus.res_valid, 1);
    endtask
    initial begin
        int c, n, seen;
        int exp3 [3];
        exp3 = '{50, 64, 64};
        vecs[0] = '{G, 7'd64};
        vecs[1] = '{64'h0, 7'd50};
        vecs[2] = '{~G, 7'd0};
        vecs[3] = '{G ^ 64'h1, 7'd63};
        vecs[4] = '{G ^ 64'hF000_0000_0000_000F, 7'd56};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd14};
        for (int i = 0; i < 16; i++) tab[i] = '0;
        bus.res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_sel", bus.cand_sel, 0);
        chk("rst_best", best_score, 0);
        chk("rst_dp_a1", bus.dp_a1, 0);
        rst_n = 1;
        @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            tab[0] = vecs[v].y;
            kick(1);
            chk("drv_busy", busy, 1);
            chk("drv_a1", bus.dp_a1, 16'hFF00);
            chk("drv_a0", bus.dp_a0, 16'hF0F0);
            chk("drv_b1", bus.dp_b1, 16'hCCCC);
            chk("drv_b0", bus.dp_b0, 16'hAAAA);
            wait_valid(c);
            chk("valid_latency", c, 4);
            chk("vec_score", bus.res_score, vecs[v].score);
            chk("vec_cand", bus.res_cand, 0);
            @(negedge clk);
            chk("vec_done", done, 1);
            chk("vec_busy", busy, 0);
            chk("vec_best_score", best_score, vecs[v].score);
            chk("vec_best_cand", best_cand, 0);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("idle_dp_a1", bus.dp_a1, 0);
        end
        tab[0] = '0;
        tab[1] = G;
        tab[2] = G;
        kick(3);
        num_cand = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_ignored_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            wait_valid(c);
            chk("multi_cand", bus.res_cand, k);
            chk("multi_score", bus.res_score, exp3[k]);
            @(negedge clk);
        end
        chk("multi_done", done, 1);
        chk("multi_best_cand", best_cand, 1);
        chk("multi_best_score", best_score, 64);
        @(negedge clk);
        kick(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_best", best_score, 0);
        @(negedge clk);
        bus.res_ready = 0;
        tab[0] = G ^ 64'h1;
        tab[1] = '0;
        kick(2);
        wait_valid(c);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_score", bus.res_score, 63);
            chk("bp_cand", bus.res_cand, 0);
            chk("bp_sel", bus.cand_sel, 0);
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("bp_advance", bus.cand_sel, 1);
        chk("bp_valid_drop", bus.res_valid, 0);
        wait_valid(c);
        chk("bp_score2", bus.res_score, 50);
        chk("bp_cand2", bus.res_cand, 1);
        @(negedge clk);
        chk("bp_done", done, 1);
        chk("bp_best_score", best_score, 63);
        chk("bp_best_cand", best_cand, 0);
        @(negedge clk);
        tab[0] = '0;
        tab[1] = G;
        tab[2] = ~G;
        kick(4);
        c = 0;
        while (bus.cand_sel != 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reach", bus.cand_sel, 2);
        chk("abort_in_drive", bus.dp_a1, 16'hFF00);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.res_valid, 0);
        chk("abort_dp", bus.dp_a1, 0);
        chk("abort_best_score", best_score, 64);
        chk("abort_best_cand", best_cand, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        tab[0] = ~G;
        kick(1);
        wait_valid(c);
        chk("restart_score", bus.res_score, 0);
        chk("restart_cand", bus.res_cand, 0);
        @(negedge clk);
        chk("restart_done", done, 1);
        chk("restart_best", best_score, 0);
        @(negedge clk);
        num_cand = 1;
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        chk("abort_wins_busy", busy, 0);
        chk("abort_wins_done", done, 0);
        for (int i = 0; i < 16; i++) tab[i] = '0;
        tab[9] = G;
        kick(31);
        c = 0;
        n = 0;
        while (!done && c < 300) begin
            if (bus.res_valid) n++;
            @(negedge clk);
            c++;
        end
        chk("clamp_done", done, 1);
        chk("clamp_count", n, 16);
        chk("clamp_last_cand", bus.res_cand, 15);
        chk("clamp_best_cand", best_cand, 9);
        chk("clamp_best_score", best_score, 64);
        @(negedge clk);
        tab[0] = G;
        kick(1);
        wait_valid(c);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", bus.res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_best", best_score, 0);
        chk("arst_score", bus.res_score, 0);
        chk("arst_sel", bus.cand_sel, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
